// File: rtl/sram_arbiter_pkg.sv
// Shared types for the two-port SRAM arbiter: FSM states, command and port identifiers.
package sram_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_WAIT,
        ST_WR_SETUP,
        ST_WR_PULSE,
        ST_WR_HOLD,
        ST_DONE
    } state_t;

    typedef enum logic {
        CMD_READ  = 1'b0,
        CMD_WRITE = 1'b1
    } cmd_t;

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_t;

    // Strobe counter width: wide enough for the longer of the two strobe windows.
    function automatic int unsigned cnt_width(int unsigned rd_cycles, int unsigned we_cycles);
        int unsigned m;
        m = (rd_cycles > we_cycles) ? rd_cycles : we_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Requester-side handshake bundle: port A (instruction fetch, read-only) and port B (data, read/write).
interface sram_arbiter_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
) ();

    logic              a_req;
    logic [ADDR_W-1:0] a_addr;
    logic [DATA_W-1:0] a_rdata;
    logic              a_ack;

    logic              b_req;
    logic              b_we;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] b_wdata;
    logic [DATA_W-1:0] b_rdata;
    logic              b_ack;

    // Requesters (CPU memory stages)
    modport master (
        output a_req, a_addr,
        input  a_rdata, a_ack,
        output b_req, b_we, b_addr, b_wdata,
        input  b_rdata, b_ack
    );

    // Arbiter
    modport slave (
        input  a_req, a_addr,
        output a_rdata, a_ack,
        input  b_req, b_we, b_addr, b_wdata,
        output b_rdata, b_ack
    );

endinterface

// File: rtl/sram_bus_driver.sv
// Tri-state driver for the SRAM data pins; also returns the value currently on the bus.
module sram_bus_driver #(
    parameter int DATA_W = 16
) (
    input  logic              drv_en,
    input  logic [DATA_W-1:0] wdata,
    inout  wire  [DATA_W-1:0] Ram1_data,
    output logic [DATA_W-1:0] rdata
);

    assign Ram1_data = drv_en ? wdata : 'z;
    assign rdata     = Ram1_data;

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing the board SRAM (Ram1) between an instruction-fetch port (A)
// and a data port (B), generating registered EN/OE/WE strobes with fixed cycle timing.
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W    = 18,
    parameter int DATA_W    = 16,
    parameter int RD_CYCLES = 2,
    parameter int WE_CYCLES = 2
) (
    input  logic              CLK,
    input  logic              RST,
    sram_arbiter_if.slave     bus,
    output logic              Ram1_EN,
    output logic              Ram1_OE,
    output logic              Ram1_WE,
    output logic [ADDR_W-1:0] Ram1_address,
    inout  wire  [DATA_W-1:0] Ram1_data,
    output logic              rdn,
    output logic              wrn
);

    localparam int unsigned CNT_W = cnt_width(RD_CYCLES, WE_CYCLES);
    localparam logic [CNT_W-1:0] RD_INIT = CNT_W'(RD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WE_INIT = CNT_W'(WE_CYCLES - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              en_q, en_d, oe_q, oe_d, we_q, we_d, drv_q, drv_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    port_t             grant_q, grant_d, last_q, last_d;
    logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
    logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
    logic [DATA_W-1:0] bus_rdata;
    port_t             sel_port;
    cmd_t              cmd;

    sram_bus_driver #(.DATA_W(DATA_W)) u_drv (
        .drv_en    (drv_q),
        .wdata     (wdata_q),
        .Ram1_data (Ram1_data),
        .rdata     (bus_rdata)
    );

    // Arbitration, strobe sequencing, read capture and completion pulses.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        en_d      = en_q;
        oe_d      = oe_q;
        we_d      = we_q;
        drv_d     = drv_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        grant_d   = grant_q;
        last_d    = last_q;
        a_ack_d   = 1'b0;
        b_ack_d   = 1'b0;
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        sel_port  = PORT_A;
        cmd       = CMD_READ;
        case (state_q)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    if (bus.a_req && bus.b_req) begin
                        sel_port = (last_q == PORT_A) ? PORT_B : PORT_A;
                    end else if (bus.b_req) begin
                        sel_port = PORT_B;
                    end
                    grant_d = sel_port;
                    last_d  = sel_port;
                    if (sel_port == PORT_A) begin
                        addr_d = bus.a_addr;
                    end else begin
                        addr_d  = bus.b_addr;
                        wdata_d = bus.b_wdata;
                        cmd     = bus.b_we ? CMD_WRITE : CMD_READ;
                    end
                    en_d = 1'b0;
                    we_d = 1'b1;
                    if (cmd == CMD_READ) begin
                        oe_d    = 1'b0;
                        cnt_d   = RD_INIT;
                        state_d = ST_RD_WAIT;
                    end else begin
                        oe_d    = 1'b1;
                        drv_d   = 1'b1;
                        state_d = ST_WR_SETUP;
                    end
                end
            end
            ST_RD_WAIT: begin
                if (cnt_q == '0) begin
                    if (grant_q == PORT_A) begin
                        a_rdata_d = bus_rdata;
                        a_ack_d   = 1'b1;
                    end else begin
                        b_rdata_d = bus_rdata;
                        b_ack_d   = 1'b1;
                    end
                    en_d    = 1'b1;
                    oe_d    = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                we_d    = 1'b0;
                cnt_d   = WE_INIT;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_q == '0) begin
                    we_d    = 1'b1;
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                // Ack is registered on entry to DONE so it is high exactly for the DONE cycle.
                en_d    = 1'b1;
                drv_d   = 1'b0;
                b_ack_d = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; reset aborts any transaction in flight.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            en_q      <= 1'b1;
            oe_q      <= 1'b1;
            we_q      <= 1'b1;
            drv_q     <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            grant_q   <= PORT_A;
            last_q    <= PORT_B;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            en_q      <= en_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            drv_q     <= drv_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign Ram1_EN      = en_q;
    assign Ram1_OE      = oe_q;
    assign Ram1_WE      = we_q;
    assign Ram1_address = addr_q;
    assign bus.a_ack    = a_ack_q;
    assign bus.b_ack    = b_ack_q;
    assign bus.a_rdata  = a_rdata_q;
    assign bus.b_rdata  = b_rdata_q;
    assign rdn          = 1'b1;
    assign wrn          = 1'b1;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural SRAM on the pins, reference memory and round-robin model.
module tb_sram_arbiter;

    localparam int ADDR_W    = 18;
    localparam int DATA_W    = 16;
    localparam int RD_CYCLES = 2;
    localparam int WE_CYCLES = 2;
    localparam int RD_LAT    = RD_CYCLES + 1;
    localparam int WR_LAT    = WE_CYCLES + 3;

    logic              clk = 1'b0;
    logic              rst;
    logic              ram1_en, ram1_oe, ram1_we, rdn, wrn;
    logic [ADDR_W-1:0] ram1_addr;
    wire  [DATA_W-1:0] ram1_data;
    logic              drv_on;
    logic              model_drive;

    logic [DATA_W-1:0] sram_mem [0:255];
    logic [DATA_W-1:0] ref_mem  [0:255];
    bit                ref_last_b;
    int                n_checks = 0;
    int                n_fail   = 0;

    sram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sram_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .RD_CYCLES (RD_CYCLES),
        .WE_CYCLES (WE_CYCLES)
    ) dut (
        .CLK          (clk),
        .RST          (rst),
        .bus          (bus),
        .Ram1_EN      (ram1_en),
        .Ram1_OE      (ram1_oe),
        .Ram1_WE      (ram1_we),
        .Ram1_address (ram1_addr),
        .Ram1_data    (ram1_data),
        .rdn          (rdn),
        .wrn          (wrn)
    );

    always #5 clk = ~clk;

    // SRAM model: asynchronous read whenever selected with outputs enabled and no write.
    assign model_drive = !ram1_en && !ram1_oe && ram1_we;
    assign ram1_data   = model_drive ? sram_mem[ram1_addr[7:0]] : 'z;
    assign drv_on      = dut.u_drv.drv_en;

    function automatic logic [DATA_W-1:0] init_val(int unsigned i);
        if (i == 16) return 16'hBEEF;
        return 16'(i * 40503) ^ 16'h5A5A;
    endfunction

    // Pin-level SRAM behaviour and timing checks on every cycle.
    task automatic monitor_loop();
        int                we_run = 0;
        logic [ADDR_W-1:0] wa = '0;
        logic [DATA_W-1:0] wd = '0;
        for (int i = 0; i < 256; i++) sram_mem[i] = init_val(i);
        forever begin
            @(negedge clk);
            n_checks++;
            if (rdn !== 1'b1 || wrn !== 1'b1) begin
                n_fail++;
                $display("FAIL serial_strobes: rdn=%b wrn=%b, required 1 1", rdn, wrn);
            end
            n_checks++;
            if (ram1_oe === 1'b0 && drv_on === 1'b1) begin
                n_fail++;
                $display("FAIL oe_vs_driver: OE=0 with driver on at %0t, required never", $time);
            end
            if (ram1_we === 1'b0) begin
                we_run++;
                if (we_run == 1) begin
                    wa = ram1_addr;
                    wd = ram1_data;
                end else begin
                    n_checks++;
                    if (ram1_addr !== wa || ram1_data !== wd) begin
                        n_fail++;
                        $display("FAIL we_stability: addr=%h data=%h, required %h %h", ram1_addr, ram1_data, wa, wd);
                    end
                end
                n_checks++;
                if (ram1_en !== 1'b0 || ram1_oe !== 1'b1 || drv_on !== 1'b1) begin
                    n_fail++;
                    $display("FAIL we_window: EN=%b OE=%b drv=%b during WE low, required 0 1 1", ram1_en, ram1_oe, drv_on);
                end
            end else if (we_run != 0) begin
                if (rst !== 1'b1) begin
                    n_checks++;
                    if (we_run != WE_CYCLES) begin
                        n_fail++;
                        $display("FAIL we_width: WE low %0d cycles, required %0d", we_run, WE_CYCLES);
                    end
                end
                sram_mem[wa[7:0]] = wd;
                we_run = 0;
            end
        end
    endtask

    // One transaction on a single port; lat = -1 if no ack within the budget.
    task automatic run_txn(input bit port_b, input bit we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, output logic [DATA_W-1:0] rdata,
                           output int lat, output int oe_low, output int we_low,
                           output logic [ADDR_W-1:0] seen_addr);
        lat = -1; oe_low = 0; we_low = 0; rdata = '0; seen_addr = '0;
        @(negedge clk);
        if (port_b) begin
            bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wdata; bus.b_req = 1'b1;
        end else begin
            bus.a_addr = addr; bus.a_req = 1'b1;
        end
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (ram1_oe === 1'b0) oe_low++;
            if (ram1_we === 1'b0) we_low++;
            if (ram1_en === 1'b0 && seen_addr == '0) seen_addr = ram1_addr;
            if ((port_b ? bus.b_ack : bus.a_ack) === 1'b1) begin
                lat = i;
                rdata = port_b ? bus.b_rdata : bus.a_rdata;
                break;
            end
        end
        bus.a_req = 1'b0;
        bus.b_req = 1'b0;
        if (lat > 0) begin
            ref_last_b = port_b;
            if (port_b && we) ref_mem[addr[7:0]] = wdata;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({ram1_en, ram1_oe, ram1_we} !== 3'b111) begin
            n_fail++;
            $display("FAIL reset_strobes: EN/OE/WE=%b, required 111", {ram1_en, ram1_oe, ram1_we});
        end
        n_checks++;
        if (ram1_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr: %h, required 0", ram1_addr);
        end
        n_checks++;
        if (bus.a_ack !== 1'b0 || bus.b_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ack: a=%b b=%b, required 0 0", bus.a_ack, bus.b_ack);
        end
        n_checks++;
        if (bus.a_rdata !== '0 || bus.b_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: a=%h b=%h, required 0 0", bus.a_rdata, bus.b_rdata);
        end
        n_checks++;
        if (drv_on !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_driver: drv=%b, required 0", drv_on);
        end
        rst = 1'b0;
        ref_last_b = 1'b1;
    endtask

    task automatic test_read_a();
        logic [DATA_W-1:0] rd; logic [ADDR_W-1:0] sa; int lat, ol, wl;
        run_txn(1'b0, 1'b0, 18'h00010, '0, rd, lat, ol, wl, sa);
        n_checks++;
        if (lat != RD_LAT) begin
            n_fail++;
            $display("FAIL read_a_latency: %0d, required %0d", lat, RD_LAT);
        end
        n_checks++;
        if (rd !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL read_a_data: %h, required BEEF", rd);
        end
        n_checks++;
        if (ol != RD_CYCLES || wl != 0) begin
            n_fail++;
            $display("FAIL read_a_strobes: OE low %0d WE low %0d, required %0d 0", ol, wl, RD_CYCLES);
        end
        n_checks++;
        if (sa !== 18'h00010 || ram1_en !== 1'b1) begin
            n_fail++;
            $display("FAIL read_a_addr_en: addr=%h EN in ack=%b, required 00010 1", sa, ram1_en);
        end
    endtask

    task automatic test_write_read_b();
        logic [DATA_W-1:0] rd; logic [ADDR_W-1:0] sa; int lat, ol, wl;
        run_txn(1'b1, 1'b1, 18'h00020, 16'h1234, rd, lat, ol, wl, sa);
        n_checks++;
        if (lat != WR_LAT || wl != WE_CYCLES || ol != 0) begin
            n_fail++;
            $display("FAIL write_b_timing: lat=%0d WE low=%0d OE low=%0d, required %0d %0d 0", lat, wl, ol, WR_LAT, WE_CYCLES);
        end
        n_checks++;
        if (drv_on !== 1'b0 || sa !== 18'h00020) begin
            n_fail++;
            $display("FAIL write_b_bus: drv after=%b addr=%h, required 0 00020", drv_on, sa);
        end
        run_txn(1'b1, 1'b0, 18'h00020, '0, rd, lat, ol, wl, sa);
        n_checks++;
        if (rd !== 16'h1234 || lat != RD_LAT) begin
            n_fail++;
            $display("FAIL read_b_back: data=%h lat=%0d, required 1234 %0d", rd, lat, RD_LAT);
        end
        n_checks++;
        if (bus.a_rdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL a_rdata_hold: %h, required BEEF", bus.a_rdata);
        end
    endtask

    task automatic test_round_robin();
        bit exp_b, prev_a, prev_b;
        int n;
        logic [ADDR_W-1:0] aaddr;
        @(negedge clk);
        exp_b = !ref_last_b;
        aaddr = 18'(128 + $urandom_range(0, 127));
        bus.a_addr = aaddr; bus.a_req = 1'b1;
        bus.b_we = 1'b1; bus.b_addr = 18'($urandom_range(0, 127)); bus.b_wdata = 16'($urandom); bus.b_req = 1'b1;
        n = 0; prev_a = 1'b0; prev_b = 1'b0;
        for (int cyc = 0; cyc < 100 && n < 4; cyc++) begin
            @(negedge clk);
            n_checks++;
            if ((bus.a_ack && prev_a) || (bus.b_ack && prev_b)) begin
                n_fail++;
                $display("FAIL rr_ack_width: ack held two cycles (a=%b b=%b), required single", bus.a_ack, bus.b_ack);
            end
            prev_a = bus.a_ack; prev_b = bus.b_ack;
            if (bus.a_ack === 1'b1 || bus.b_ack === 1'b1) begin
                n_checks++;
                if (bus.b_ack !== exp_b || bus.a_ack !== !exp_b) begin
                    n_fail++;
                    $display("FAIL rr_order: grant %0d a=%b b=%b, required b=%b", n, bus.a_ack, bus.b_ack, exp_b);
                end
                if (bus.a_ack === 1'b1) begin
                    n_checks++;
                    if (bus.a_rdata !== ref_mem[aaddr[7:0]]) begin
                        n_fail++;
                        $display("FAIL rr_a_data: %h, required %h", bus.a_rdata, ref_mem[aaddr[7:0]]);
                    end
                    aaddr = 18'(128 + $urandom_range(0, 127));
                    bus.a_addr = aaddr;
                end
                if (bus.b_ack === 1'b1) begin
                    ref_mem[bus.b_addr[7:0]] = bus.b_wdata;
                    bus.b_addr = 18'($urandom_range(0, 127)); bus.b_wdata = 16'($urandom);
                end
                ref_last_b = bus.b_ack;
                exp_b = !exp_b;
                n++;
            end
        end
        bus.a_req = 1'b0; bus.b_req = 1'b0;
        n_checks++;
        if (n != 4) begin
            n_fail++;
            $display("FAIL rr_count: %0d grants, required 4", n);
        end
    endtask

    task automatic test_back_to_back();
        int k, last_ack;
        @(negedge clk);
        bus.b_we = 1'b1; bus.b_addr = '0; bus.b_wdata = '0; bus.b_req = 1'b1;
        k = 0; last_ack = 0;
        for (int cyc = 1; cyc <= 200 && k < 4; cyc++) begin
            @(negedge clk);
            if (bus.b_ack === 1'b1) begin
                ref_mem[k] = 16'(k);
                if (k > 0) begin
                    n_checks++;
                    if (cyc - last_ack != WR_LAT + 1) begin
                        n_fail++;
                        $display("FAIL btb_spacing: ack gap %0d, required %0d", cyc - last_ack, WR_LAT + 1);
                    end
                end
                last_ack = cyc;
                k++;
                bus.b_addr = 18'(k); bus.b_wdata = 16'(k);
            end
        end
        bus.b_req = 1'b0;
        ref_last_b = 1'b1;
        n_checks++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL btb_count: %0d acks, required 4", k);
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (sram_mem[i] !== ref_mem[i]) begin
                n_fail++;
                $display("FAIL btb_contents: mem[%0d]=%h, required %h", i, sram_mem[i], ref_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_write();
        bit seen;
        logic [ADDR_W-1:0] wa, aa, sa;
        logic [DATA_W-1:0] rd;
        int lat, ol, wl;
        @(negedge clk);
        wa = 18'(64 + $urandom_range(0, 63));
        bus.b_we = 1'b1; bus.b_addr = wa; bus.b_wdata = ref_mem[wa[7:0]]; bus.b_req = 1'b1;
        seen = 1'b0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (ram1_we === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_mid_reach: WE never went low, required low within 20 cycles");
        end
        rst = 1'b1;
        bus.b_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({ram1_en, ram1_oe, ram1_we} !== 3'b111 || drv_on !== 1'b0 || bus.b_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_abort: EN/OE/WE=%b drv=%b b_ack=%b, required 111 0 0",
                     {ram1_en, ram1_oe, ram1_we}, drv_on, bus.b_ack);
        end
        @(negedge clk);
        rst = 1'b0;
        ref_last_b = 1'b1;
        n_checks++;
        if (bus.b_ack !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_noack: b_ack=%b, required 0", bus.b_ack);
        end
        aa = 18'($urandom_range(128, 255));
        run_txn(1'b0, 1'b0, aa, '0, rd, lat, ol, wl, sa);
        n_checks++;
        if (lat != RD_LAT || rd !== ref_mem[aa[7:0]]) begin
            n_fail++;
            $display("FAIL rst_mid_post_read: lat=%0d data=%h, required %0d %h", lat, rd, RD_LAT, ref_mem[aa[7:0]]);
        end
    endtask

    task automatic test_random();
        bit pb, w;
        logic [ADDR_W-1:0] addr, sa;
        logic [DATA_W-1:0] wd, rd, exp_rd;
        int lat, ol, wl;
        for (int t = 0; t < 24; t++) begin
            pb = 1'($urandom_range(0, 1));
            w = pb ? 1'($urandom_range(0, 1)) : 1'b0;
            addr = 18'($urandom_range(0, 255));
            wd = 16'($urandom);
            exp_rd = ref_mem[addr[7:0]];
            run_txn(pb, w, addr, wd, rd, lat, ol, wl, sa);
            n_checks++;
            if (lat != (w ? WR_LAT : RD_LAT) || sa !== addr) begin
                n_fail++;
                $display("FAIL rand_timing[%0d]: lat=%0d addr=%h, required %0d %h", t, lat, sa, w ? WR_LAT : RD_LAT, addr);
            end
            if (!w) begin
                n_checks++;
                if (rd !== exp_rd) begin
                    n_fail++;
                    $display("FAIL rand_read[%0d]: port %s addr %h data %h, required %h", t, pb ? "B" : "A", addr, rd, exp_rd);
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.a_req = 1'b0; bus.a_addr = '0;
        bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        fork
            monitor_loop();
        join_none
        test_reset();
        test_read_a();
        test_write_read_b();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_write();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
